spike_class_decoder: RTL and testbench

SPIKE_CLASS_DECODER -- requirements
Module: spike_class_decoder

---
 rtl/spike_class_decoder.sv | 158 +++++++++++++++
 tb/tb_spike_class_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_class_decoder.sv
// Counts rising edges per output neuron over a fixed window, then serially scans the counts
// to report the winning neuron index, its count, and tie / no-spike flags.
module spike_class_decoder #(
  parameter int unsigned NEURON_OUT = 6,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned WIN_CYCLES = 40000,
  parameter int unsigned CLS_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NEURON_OUT-1:0] Spikes_in,
  input  logic                  START,
  input  logic                  ACK,
  output logic [CLS_W-1:0]      CLASS,
  output logic                  VALID,
  output logic                  TIE,
  output logic                  NO_SPIKE,
  output logic [CNT_W-1:0]      WIN_CNT,
  output logic                  BUSY
);

  localparam int unsigned TMR_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(NEURON_OUT + 1);

  typedef enum logic [1:0] {StIdle, StCount, StDecide, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [NEURON_OUT-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q [NEURON_OUT];
  logic [CNT_W-1:0]        cnt_d [NEURON_OUT];
  logic [IDX_W-1:0]        scan_q, scan_d;
  logic [CLS_W-1:0]        best_idx_q, best_idx_d;
  logic [CNT_W-1:0]        best_cnt_q, best_cnt_d;
  logic                    tie_q, tie_d;
  logic [CLS_W-1:0]        class_q, class_d;
  logic                    valid_q, valid_d;
  logic                    tie_out_q, tie_out_d;
  logic                    no_spike_q, no_spike_d;
  logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]        cur_cnt;
  logic                    start_win;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    tie_d      = tie_q;
    class_d    = class_q;
    valid_d    = valid_q;
    tie_out_d  = tie_out_q;
    no_spike_d = no_spike_q;
    win_cnt_d  = win_cnt_q;
    cur_cnt    = '0;
    for (int i = 0; i < NEURON_OUT; i++) begin
      if (scan_q == IDX_W'(i)) cur_cnt = cnt_q[i];
    end
    // START is honoured everywhere except while the scan is in progress
    start_win = START && (state_q != StDecide);

    unique case (state_q)
      StIdle: ;
      StCount: begin
        for (int i = 0; i < NEURON_OUT; i++) begin
          if (Spikes_in[i] && !prev_q[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        prev_d = Spikes_in;
        if (timer_q == '0) begin
          state_d    = StDecide;
          scan_d     = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          tie_d      = 1'b0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      StDecide: begin
        if (scan_q == IDX_W'(NEURON_OUT)) begin
          state_d    = StDone;
          valid_d    = 1'b1;
          win_cnt_d  = best_cnt_q;
          no_spike_d = (best_cnt_q == '0);
          class_d    = (best_cnt_q == '0) ? '1 : best_idx_q;
          tie_out_d  = tie_q && (best_cnt_q != '0);
        end else begin
          if (cur_cnt > best_cnt_q) begin
            best_cnt_d = cur_cnt;
            best_idx_d = CLS_W'(scan_q);
            tie_d      = 1'b0;
          end else if ((cur_cnt == best_cnt_q) && (cur_cnt != '0)) begin
            tie_d = 1'b1;
          end
          scan_d = scan_q + IDX_W'(1);
        end
      end
      StDone: begin
        if (ACK) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_win) begin
      state_d = StCount;
      timer_d = TMR_W'(WIN_CYCLES - 1);
      prev_d  = '0;
      valid_d = 1'b0;
      for (int i = 0; i < NEURON_OUT; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '{default: '0};
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      tie_q      <= 1'b0;
      class_q    <= '0;
      valid_q    <= 1'b0;
      tie_out_q  <= 1'b0;
      no_spike_q <= 1'b0;
      win_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      tie_q      <= tie_d;
      class_q    <= class_d;
      valid_q    <= valid_d;
      tie_out_q  <= tie_out_d;
      no_spike_q <= no_spike_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

  assign CLASS    = class_q;
  assign VALID    = valid_q;
  assign TIE      = tie_out_q;
  assign NO_SPIKE = no_spike_q;
  assign WIN_CNT  = win_cnt_q;
  assign BUSY     = (state_q == StCount) || (state_q == StDecide);

endmodule

// File: tb/tb_spike_class_decoder.sv
// Directed bench for spike_class_decoder with a 100-cycle window, 6 neurons, 4-bit counters.
module tb_spike_class_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Spikes_in;
  logic       START;
  logic       ACK;
  logic [2:0] CLASS;
  logic       VALID;
  logic       TIE;
  logic       NO_SPIKE;
  logic [3:0] WIN_CNT;
  logic       BUSY;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;

  spike_class_decoder #(
    .NEURON_OUT(6),
    .CNT_W     (4),
    .WIN_CYCLES(100),
    .CLS_W     (3)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Spikes_in(Spikes_in),
    .START    (START),
    .ACK      (ACK),
    .CLASS    (CLASS),
    .VALID    (VALID),
    .TIE      (TIE),
    .NO_SPIKE (NO_SPIKE),
    .WIN_CNT  (WIN_CNT),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
    edges++;
  endtask

  // START is sampled by the edge numbered 0
  task automatic open_window;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    edges = 0;
  endtask

  task automatic pulse(input logic [5:0] m);
    Spikes_in = m;
    tick();
    Spikes_in = '0;
    tick();
  endtask

  task automatic wait_valid;
    while (VALID !== 1'b1 && edges < 300) tick();
  endtask

  task automatic test_reset;
    n_vec++; if (CLASS !== 3'd0) begin n_err++; $display("FAIL reset_class got %0d expected 0", CLASS); end
    n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b expected 0", VALID); end
    n_vec++; if (TIE !== 1'b0) begin n_err++; $display("FAIL reset_tie got %0b expected 0", TIE); end
    n_vec++; if (NO_SPIKE !== 1'b0) begin n_err++; $display("FAIL reset_nospike got %0b expected 0", NO_SPIKE); end
    n_vec++; if (WIN_CNT !== 4'd0) begin n_err++; $display("FAIL reset_wincnt got %0d expected 0", WIN_CNT); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b expected 0", BUSY); end
  endtask

  task automatic test_winner;
    open_window();
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL win_busy got %0b expected 1", BUSY); end
    for (int k = 0; k < 5; k++) pulse((k < 3) ? 6'b010100 : 6'b000100);
    while (edges < 106) tick();
    n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL win_early got %0b expected 0", VALID); end
    wait_valid();
    n_vec++; if (edges !== 107) begin n_err++; $display("FAIL win_latency got %0d expected 107", edges); end
    n_vec++; if (CLASS !== 3'd2) begin n_err++; $display("FAIL win_class got %0d expected 2", CLASS); end
    n_vec++; if (WIN_CNT !== 4'd5) begin n_err++; $display("FAIL win_cnt got %0d expected 5", WIN_CNT); end
    n_vec++; if (TIE !== 1'b0) begin n_err++; $display("FAIL win_tie got %0b expected 0", TIE); end
    n_vec++; if (NO_SPIKE !== 1'b0) begin n_err++; $display("FAIL win_nospike got %0b expected 0", NO_SPIKE); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL win_busy_done got %0b expected 0", BUSY); end
    repeat (5) tick();
    n_vec++; if (VALID !== 1'b1 || CLASS !== 3'd2) begin
      n_err++; $display("FAIL win_hold got valid=%0b class=%0d expected valid=1 class=2", VALID, CLASS);
    end
    ACK = 1'b1; tick(); ACK = 1'b0;
    n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL win_ack got %0b expected 0", VALID); end
  endtask

  task automatic test_tie;
    open_window();
    ACK = 1'b1; tick(); ACK = 1'b0;
    for (int k = 0; k < 4; k++) pulse(6'b001010);
    while (edges < 101) tick();
    START = 1'b1; tick(); START = 1'b0;
    wait_valid();
    n_vec++; if (edges !== 107) begin n_err++; $display("FAIL tie_latency got %0d expected 107", edges); end
    n_vec++; if (CLASS !== 3'd1) begin n_err++; $display("FAIL tie_class got %0d expected 1", CLASS); end
    n_vec++; if (TIE !== 1'b1) begin n_err++; $display("FAIL tie_flag got %0b expected 1", TIE); end
    n_vec++; if (WIN_CNT !== 4'd4) begin n_err++; $display("FAIL tie_cnt got %0d expected 4", WIN_CNT); end
    ACK = 1'b1; tick(); ACK = 1'b0;
  endtask

  task automatic test_no_spike;
    open_window();
    wait_valid();
    n_vec++; if (edges !== 107) begin n_err++; $display("FAIL nospk_latency got %0d expected 107", edges); end
    n_vec++; if (CLASS !== 3'd7) begin n_err++; $display("FAIL nospk_class got %0d expected 7", CLASS); end
    n_vec++; if (NO_SPIKE !== 1'b1) begin n_err++; $display("FAIL nospk_flag got %0b expected 1", NO_SPIKE); end
    n_vec++; if (TIE !== 1'b0) begin n_err++; $display("FAIL nospk_tie got %0b expected 0", TIE); end
    n_vec++; if (WIN_CNT !== 4'd0) begin n_err++; $display("FAIL nospk_cnt got %0d expected 0", WIN_CNT); end
    ACK = 1'b1; tick(); ACK = 1'b0;
    n_vec++; if (VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL nospk_ack got valid=%0b busy=%0b expected 0 0", VALID, BUSY);
    end
  endtask

  task automatic test_saturate;
    open_window();
    for (int k = 0; k < 20; k++) begin
      Spikes_in = 6'b100001; tick();
      Spikes_in = 6'b100000; tick();
    end
    while (edges < 102) tick();
    Spikes_in = '0;
    wait_valid();
    n_vec++; if (CLASS !== 3'd0) begin n_err++; $display("FAIL sat_class got %0d expected 0", CLASS); end
    n_vec++; if (WIN_CNT !== 4'd15) begin n_err++; $display("FAIL sat_cnt got %0d expected 15", WIN_CNT); end
    n_vec++; if (TIE !== 1'b0) begin n_err++; $display("FAIL sat_tie got %0b expected 0", TIE); end
    ACK = 1'b1; tick(); ACK = 1'b0;
  endtask

  task automatic test_restart;
    open_window();
    while (edges < 39) tick();
    for (int k = 0; k < 3; k++) pulse(6'b000001);
    while (edges < 49) tick();
    open_window();
    for (int k = 0; k < 2; k++) pulse(6'b000010);
    wait_valid();
    n_vec++; if (edges !== 107) begin n_err++; $display("FAIL rst_win_latency got %0d expected 107", edges); end
    n_vec++; if (CLASS !== 3'd1) begin n_err++; $display("FAIL rst_win_class got %0d expected 1", CLASS); end
    n_vec++; if (WIN_CNT !== 4'd2) begin n_err++; $display("FAIL rst_win_cnt got %0d expected 2", WIN_CNT); end
  endtask

  task automatic test_back_to_back;
    ACK = 1'b1;
    open_window();
    ACK = 1'b0;
    n_vec++; if (VALID !== 1'b0 || BUSY !== 1'b1) begin
      n_err++; $display("FAIL b2b_restart got valid=%0b busy=%0b expected 0 1", VALID, BUSY);
    end
    pulse(6'b010000);
    wait_valid();
    n_vec++; if (edges !== 107) begin n_err++; $display("FAIL b2b_latency got %0d expected 107", edges); end
    n_vec++; if (CLASS !== 3'd4 || WIN_CNT !== 4'd1) begin
      n_err++; $display("FAIL b2b_result got class=%0d cnt=%0d expected 4 1", CLASS, WIN_CNT);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    open_window();
    pulse(6'b001000);
    while (edges < 60) tick();
    #2 RST = 1'b1;
    #1;
    n_vec++; if (CLASS !== 3'd0 || WIN_CNT !== 4'd0 || BUSY !== 1'b0 || VALID !== 1'b0) begin
      n_err++; $display("FAIL rstmid_outputs got class=%0d cnt=%0d busy=%0b valid=%0b expected all 0",
                        CLASS, WIN_CNT, BUSY, VALID);
    end
    tick();
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (VALID !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet got activity=1 expected 0"); end
  endtask

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    ACK       = 1'b0;
    Spikes_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    RST = 1'b0;
    tick();
    test_winner();
    test_tie();
    test_no_spike();
    test_saturate();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
